// File: rtl/io_dispatch.sv
// io_dispatch: memory-mapped I/O dispatcher between the core data port,
// system RAM (page 0) and NCH peripheral channels.
// Page map (P = addr[ADDR_W-1:PAGE_LSB]):
//   0          RAM
//   1..NCH     channel P-1 data (cleared-on-read pending, one-cycle ch_ack)
//   NCH+1      STATUS (pending, read only)
//   NCH+2      MASK   (read/write)
//   other      unmapped, reads 0, writes ignored
// Optional feature macro: IO_DISPATCH_SNAPSHOT_EN -- per-channel snapshot
// registers captured on accepted events; channel reads return the snapshot
// instead of the live channel bus.
module io_dispatch #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 24,
    parameter int PAGE_LSB = 16,
    parameter int RAM_AW   = 15,
    parameter int NCH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [NCH-1:0]        ch_event,
    output logic [NCH-1:0]        ch_ack,
    output logic                  irq
);

    localparam int PW = ADDR_W - PAGE_LSB;
    localparam logic [PW-1:0] PAGE_STATUS = PW'(NCH + 1);
    localparam logic [PW-1:0] PAGE_MASK   = PW'(NCH + 2);

    logic [PW-1:0]      page;
    logic               page_ram;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q;
    logic [NCH-1:0]     ch_ack_q, ch_ack_d;
    logic               irq_q;
    logic [NCH-1:0]     pending_q, pending_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [NCH-1:0]     ev_accept;
    logic [DATA_W-1:0]  chan_val [NCH];

    assign page      = addr[ADDR_W-1:PAGE_LSB];
    assign page_ram  = (page == '0);
    assign ram_addr  = addr[RAM_AW-1:0];
    assign ram_we    = we && page_ram;
    assign ram_wdata = wdata;

    // Events only count while their channel is enabled
    assign ev_accept = ch_event & mask_q;

`ifdef IO_DISPATCH_SNAPSHOT_EN
    logic [DATA_W-1:0] snap_q [NCH];

    // Capture channel data at each accepted event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (ev_accept[i]) snap_q[i] <= ch_data[i*DATA_W +: DATA_W];
        end
    end

    // Channel reads see the captured value
    always_comb begin
        for (int i = 0; i < NCH; i++) chan_val[i] = snap_q[i];
    end
`else
    // Channel reads see the live channel bus
    always_comb begin
        for (int i = 0; i < NCH; i++) chan_val[i] = ch_data[i*DATA_W +: DATA_W];
    end
`endif

    // Read mux, acknowledge/clear decode, pending and mask next state
    always_comb begin
        rd_data_d = '0;
        ch_ack_d  = '0;
        mask_d    = mask_q;
        if (page_ram) begin
            rd_data_d = ram_rdata;
        end else if (page == PAGE_STATUS) begin
            rd_data_d[NCH-1:0] = pending_q;
        end else if (page == PAGE_MASK) begin
            rd_data_d[NCH-1:0] = mask_q;
        end
        for (int i = 0; i < NCH; i++) begin
            if (page == PW'(i + 1)) begin
                rd_data_d   = chan_val[i];
                ch_ack_d[i] = re;
            end
        end
        if (we && page == PAGE_MASK) mask_d = wdata[NCH-1:0];
        // A same-cycle event beats the read clear
        pending_d = (pending_q & ~ch_ack_d) | ev_accept;
    end

    // Registered read port, acknowledges, interrupt and channel state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ch_ack_q   <= '0;
            irq_q      <= 1'b0;
            pending_q  <= '0;
            mask_q     <= '1;
        end else begin
            if (re) rd_data_q <= rd_data_d;
            rd_valid_q <= re;
            ch_ack_q   <= ch_ack_d;
            irq_q      <= |(pending_q & mask_q);
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ch_ack   = ch_ack_q;
    assign irq      = irq_q;

endmodule

// File: doc/io_dispatch.md
# io_dispatch

Parametrised memory-mapped I/O dispatcher between the core's data port and the system RAM plus NCH peripheral channels (encoders, accelerometer, and similar). It decodes the page field of the core address, forwards page-0 traffic to RAM, and returns registered read data. Each channel has a sticky event-pending bit that is cleared on read, a one-cycle read acknowledge back to the peripheral, and a per-channel enable mask. Masked pending events raise a single interrupt to the core.

## Interface
Parameters:
- DATA_W, 16, data width of core, RAM and channel buses
- ADDR_W, 24, core address width
- PAGE_LSB, 16, lowest bit of the page field addr[ADDR_W-1:PAGE_LSB]
- RAM_AW, 15, RAM address width (must be <= PAGE_LSB)
- NCH, 4, number of peripheral channels (1..8)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  core address
- re  in  1  core read strobe, one cycle per access
- we  in  1  core write strobe
- wdata  in  DATA_W  core write data
- rd_data  out  DATA_W  registered read data to core
- rd_valid  out  1  rd_data valid, one-cycle pulse
- ram_addr  out  RAM_AW  addr[RAM_AW-1:0], combinational
- ram_we  out  1  we AND page==0, combinational
- ram_wdata  out  DATA_W  wdata, combinational
- ram_rdata  in  DATA_W  asynchronous-read RAM data
- ch_data  in  NCH*DATA_W  channel i on bits [i*DATA_W +: DATA_W]
- ch_event  in  NCH  per-channel new-data pulse
- ch_ack  out  NCH  one-cycle "has been read" pulse per channel
- irq  out  1  registered OR of (pending AND mask)

## Operation
- Page map (P = addr[ADDR_W-1:PAGE_LSB]):
  - P=0: RAM.
  - P=1..NCH: channel P-1 data.
  - P=NCH+1: STATUS, pending[NCH-1:0] zero-extended.
  - P=NCH+2: MASK, read/write, mask[NCH-1:0].
  - Any other page: unmapped, reads 0 and ignores writes.
- Writes:
  - Only P=0 asserts ram_we.
  - P=NCH+2 loads mask from wdata[NCH-1:0].
  - Writes to channel, STATUS and unmapped pages are dropped.
- pending[i]:
  - Set on ch_event[i] when mask[i]=1. Events are ignored when mask[i]=0.
  - Cleared when the core reads page i+1 (re=1).
  - Set and clear in the same cycle: set wins and pending stays 1.
- ch_ack[i]: one cycle, asserted the cycle after a read of page i+1, whatever the state of pending.
- A STATUS read does not clear pending.
- Clearing a mask bit does not clear its pending bit. irq ignores that bit until the mask bit is set again.
- re and we asserted together: both actions happen. Read data returns the pre-write value.

## Timing
- Reset values: rd_data=0, rd_valid=0, ch_ack=0, irq=0, pending=0, mask=all ones, snapshot registers=0.
- Read latency is 1 cycle. With re at edge N, rd_data and rd_valid are valid after edge N+1. ram_rdata is sampled at edge N.
- rd_data holds its value until the next read. rd_valid is high for exactly one cycle per re.
- Back-to-back reads are allowed every cycle with no stall.
- irq is registered: high one cycle after pending&mask becomes non-zero, low one cycle after it becomes zero.
- ram_addr, ram_we and ram_wdata are combinational pass-through with zero latency.
- Asserting rst mid-access aborts it: no rd_valid and no ch_ack are produced for that access.

## Configuration
- IO_DISPATCH_SNAPSHOT_EN defined:
  - Each channel has a DATA_W snapshot register, loaded from ch_data[i] on every accepted event (ch_event[i] with mask[i]=1).
  - A channel read returns the snapshot.
  - Snapshots reset to 0.
- Undefined: a channel read returns live ch_data[i] sampled at the re edge, and no snapshot registers exist.

## Test plan
- Reset, then read P=NCH+2 -> rd_data=16'h000F (NCH=4) one cycle later, with rd_valid for one cycle. irq=0 and ch_ack=0.
- Write 16'hBEEF to addr 24'h000123 -> ram_we=1 and ram_addr=15'h0123 in the same cycle. A read of the same address with ram_rdata=16'hBEEF -> rd_data=16'hBEEF one cycle later.
- Pulse ch_event[2] -> STATUS reads 16'h0004 and irq=1. A read of addr 24'h030000 -> ch_ack[2] pulses once, STATUS then reads 0, and irq drops one cycle after pending clears.
- Write MASK=16'h0001, then pulse ch_event[1] -> STATUS=0 and irq stays 0. Pulse ch_event[0] -> irq=1.
- Read channel 0 in the same cycle ch_event[0] pulses -> pending[0] remains 1 and ch_ack[0] pulses.
- With IO_DISPATCH_SNAPSHOT_EN: set ch_data[0]=16'h1234 and pulse the event, then change ch_data[0] to 16'h5678 -> a read of page 1 returns 16'h1234. Without the macro the same read returns 16'h5678. A read of unmapped page 8'h20 -> 16'h0000.
